mic_sample_scheduler: RTL and testbench

- Periodic sample sequencer for the SPI microphone path, in the PCLK domain.
- Generates the sample-rate tick and issues one start request per tick to the SPI master.
- Captures each returned 16-bit sample into a circular buffer; the CPU drains it over APB.
- Raises a level interrupt at a programmable fill watermark or on overflow.

---
 rtl/mic_sched_pkg.sv | 20 ++
 rtl/mic_sample_fifo.sv | 49 ++++
 rtl/mic_sample_scheduler.sv | 99 +++++++++
 tb/tb_mic_sample_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mic_sched_pkg.sv
// mic_sched_pkg: shared types and constants for the microphone sample scheduler
//   state_t      - sequencer states
//   OFF_*        - APB register offsets (PADDR[4:0])
//   DIV_RST      - reset tick period, BAD_ADDR - read value of unmapped offsets
//   ST_*         - STATUS bit positions
package mic_sched_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_REQ, ST_WAIT} state_t;
  localparam logic [4:0] OFF_CTRL = 5'h00;
  localparam logic [4:0] OFF_DIV = 5'h04;
  localparam logic [4:0] OFF_WMARK = 5'h08;
  localparam logic [4:0] OFF_STATUS = 5'h0C;
  localparam logic [4:0] OFF_DATA = 5'h10;
  localparam logic [15:0] DIV_RST = 16'd1000;
  localparam logic [31:0] BAD_ADDR = 32'hDEADDEAD;
  localparam int ST_EMPTY = 8;
  localparam int ST_FULL = 9;
  localparam int ST_OVF = 10;
  localparam int ST_LATE = 11;
  localparam int ST_BUSY = 12;
endpackage

// File: rtl/mic_sample_fifo.sv
// mic_sample_fifo: circular buffer of 16-bit samples
//   PCLK/PRESETn  clock, async active-low reset
//   i_push/i_din  write a sample (dropped when full unless popping the same cycle)
//   i_pop         remove head (ignored when empty)
//   i_clr         flush pointers and count, wins over push/pop
//   o_dout        current head, o_count/o_full/o_empty fill state
module mic_sample_fifo #(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_clr,
  input  logic [15:0]   i_din,
  output logic [15:0]   o_dout,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty
);
  logic [15:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign o_count = r_count;
  assign o_full = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_dout = r_mem[r_rptr];
  assign w_pop = i_pop & ~o_empty;
  // a coincident pop frees the slot, so a push into a full buffer still lands
  assign w_push = i_push & (~o_full | w_pop);
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge PCLK)
    if (w_push && !i_clr) r_mem[r_wptr] <= i_din;
endmodule

// File: rtl/mic_sample_scheduler.sv
// mic_sample_scheduler: periodic SPI microphone sampler with APB-drained buffer
//   PCLK/PRESETn            clock, async active-low reset
//   PSEL..PWDATA/PRDATA     APB slave, zero wait states, PADDR[4:0] decoded
//   PREADY/PSLVERR          always ready; error on DATA read while empty
//   spi_start               one-cycle transfer request to the SPI master
//   spi_done/spi_data       returned sample, valid for one cycle
//   irq                     registered level: watermark reached or overflow
module mic_sample_scheduler
  import mic_sched_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [11:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        spi_start,
  input  logic        spi_done,
  input  logic [15:0] spi_data,
  output logic        irq
);
  state_t r_state, w_next;
  logic r_en, r_ovf, r_late, r_irq;
  logic [15:0] r_div, r_cnt;
  logic [AW:0] r_wmark;
  logic w_wr, w_rd, w_clr, w_tick, w_push, w_pop, w_pop_ok, w_full, w_empty, w_busy, w_st_wr;
  logic [4:0] w_off;
  logic [15:0] w_div_eff, w_dout;
  logic [AW:0] w_count;
  logic [31:0] w_status;
  logic w_unused;
  assign w_unused = ^{PADDR[11:5], PWDATA[31:16]};
  assign w_off = PADDR[4:0];
  assign w_wr = PSEL & PENABLE & PWRITE;
  assign w_rd = PSEL & PENABLE & ~PWRITE;
  assign w_clr = w_wr && w_off == OFF_CTRL && PWDATA[1];
  assign w_st_wr = w_wr && w_off == OFF_STATUS;
  assign w_pop = w_rd && w_off == OFF_DATA;
  assign w_pop_ok = w_pop & ~w_empty;
  assign w_push = r_state == ST_WAIT && spi_done;
  assign w_div_eff = r_div < 16'd4 ? 16'd4 : r_div;
  assign w_tick = r_en && r_cnt == w_div_eff - 16'd1;
  assign w_busy = r_state == ST_REQ || r_state == ST_WAIT;
  assign spi_start = r_state == ST_REQ;
  assign PREADY = 1'b1;
  assign PSLVERR = w_pop & w_empty;
  assign irq = r_irq;
  mic_sample_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .PCLK(PCLK), .PRESETn(PRESETn), .i_push(w_push), .i_pop(w_pop), .i_clr(w_clr),
    .i_din(spi_data), .o_dout(w_dout), .o_count(w_count), .o_full(w_full), .o_empty(w_empty)
  );
  always_comb begin
    w_status = 32'(w_count);
    w_status[ST_EMPTY] = w_empty;
    w_status[ST_FULL] = w_full;
    w_status[ST_OVF] = r_ovf;
    w_status[ST_LATE] = r_late;
    w_status[ST_BUSY] = w_busy;
  end
  assign PRDATA = w_off == OFF_CTRL ? {31'b0, r_en} :
                  w_off == OFF_DIV ? {16'b0, r_div} :
                  w_off == OFF_WMARK ? 32'(r_wmark) :
                  w_off == OFF_STATUS ? w_status :
                  w_off == OFF_DATA ? (w_empty ? 32'b0 : {16'b0, w_dout}) : BAD_ADDR;
  // clearing EN while waiting lets the in-flight transfer finish before idling
  always_comb
    w_next = r_state == ST_IDLE ? (r_en ? ST_ARM : ST_IDLE) :
             r_state == ST_ARM ? (!r_en ? ST_IDLE : w_tick ? ST_REQ : ST_ARM) :
             r_state == ST_REQ ? ST_WAIT :
             spi_done ? (r_en ? ST_ARM : ST_IDLE) : ST_WAIT;
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      r_state <= ST_IDLE;
      r_en <= 1'b0;
      r_div <= DIV_RST;
      r_wmark <= (AW+1)'(DEPTH / 2);
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_late <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_wr && w_off == OFF_CTRL) r_en <= PWDATA[0];
      if (w_wr && w_off == OFF_DIV) r_div <= PWDATA[15:0];
      if (w_wr && w_off == OFF_WMARK) r_wmark <= PWDATA[AW:0];
      // a DIV below the count only ticks again after the 16-bit wrap
      r_cnt <= (!r_en || w_tick) ? '0 : r_cnt + 16'd1;
      r_ovf <= w_clr ? 1'b0 : (w_push & w_full & ~w_pop_ok) ? 1'b1 : (w_st_wr & PWDATA[ST_OVF]) ? 1'b0 : r_ovf;
      r_late <= w_clr ? 1'b0 : (w_tick & w_busy) ? 1'b1 : (w_st_wr & PWDATA[ST_LATE]) ? 1'b0 : r_late;
      r_irq <= (r_wmark != '0 && w_count >= r_wmark) | r_ovf;
    end
endmodule

// File: tb/tb_mic_sample_scheduler.sv
// tb_mic_sample_scheduler: directed scoreboard bench for mic_sample_scheduler
module tb_mic_sample_scheduler;
  logic PCLK = 1'b0, PRESETn = 1'b1, PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [11:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic PREADY, PSLVERR, spi_start, irq;
  logic spi_done = 1'b0;
  logic [15:0] spi_data = '0;
  int checks = 0, errors = 0, cyc = 0, lat = 3, start_cnt = 0;
  int t0, t1, n0;
  logic [15:0] next_val = '0;
  bit spi_mute = 1'b0;
  logic [32:0] sb_q[$];
  string nm_q[$];
  logic [32:0] mon_e;
  string mon_n;
  localparam logic [11:0] A_CTRL = 12'h000, A_DIV = 12'h004, A_WMARK = 12'h008,
                          A_STATUS = 12'h00C, A_DATA = 12'h010, A_BAD = 12'h014;

  mic_sample_scheduler #(.DEPTH(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .spi_start(spi_start), .spi_done(spi_done), .spi_data(spi_data), .irq(irq)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;
  always @(negedge PCLK) if (spi_start) start_cnt <= start_cnt + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge PCLK)
    if (PSEL && PENABLE && !PWRITE) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got %h expected no read", PRDATA);
      end else begin
        mon_e = sb_q.pop_front();
        mon_n = nm_q.pop_front();
        check(mon_n, PRDATA, mon_e[31:0]);
        check({mon_n, "_slverr"}, 32'(PSLVERR), 32'(mon_e[32]));
      end
    end

  initial begin
    forever begin
      @(negedge PCLK);
      if (spi_start && !spi_mute) begin
        repeat (lat) @(posedge PCLK);
        #1 spi_done = 1'b1;
        spi_data = next_val;
        next_val = next_val + 16'd1;
        @(posedge PCLK);
        #1 spi_done = 1'b0;
      end
    end
  end

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    @(posedge PCLK);
    #1 PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge PCLK);
    #1 PENABLE = 1'b1;
    @(posedge PCLK);
    #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, input logic [31:0] d, input logic e, input string n);
    sb_q.push_back({e, d});
    nm_q.push_back(n);
    @(posedge PCLK);
    #1 PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge PCLK);
    #1 PENABLE = 1'b1;
    @(posedge PCLK);
    #1 PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wait_start(output int t);
    int n;
    n = 0;
    t = -1;
    while (n < 400) begin
      @(negedge PCLK);
      if (spi_start) begin
        t = cyc;
        break;
      end
      n++;
    end
    if (t < 0) begin
      checks++;
      errors++;
      $display("FAIL start_timeout: got no spi_start expected one within 400 cycles");
    end
  endtask

  task automatic wait_done(output int t);
    int n;
    n = 0;
    t = -1;
    while (n < 400) begin
      @(negedge PCLK);
      if (spi_done) begin
        t = cyc;
        break;
      end
      n++;
    end
    if (t < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no spi_done expected one within 400 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 PRESETn = 1'b0;
    repeat (3) @(posedge PCLK);
    #1 check("rst_spi_start", 32'(spi_start), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    PRESETn = 1'b1;
    apb_read(A_STATUS, 32'h100, 1'b0, "rst_status");
    apb_read(A_DIV, 32'd1000, 1'b0, "rst_div");
    apb_read(A_WMARK, 32'd8, 1'b0, "rst_wmark");
    apb_read(A_CTRL, 32'd0, 1'b0, "rst_ctrl");
    apb_read(A_DATA, 32'd0, 1'b1, "empty_data");
    apb_read(A_BAD, 32'hDEADDEAD, 1'b0, "bad_addr");

    apb_write(A_DIV, 32'd10);
    apb_write(A_WMARK, 32'd0);
    lat = 3;
    next_val = 16'hA001;
    apb_write(A_CTRL, 32'd1);
    wait_start(t0);
    for (int k = 0; k < 3; k++) begin
      wait_start(t1);
      check("start_period10", 32'(t1 - t0), 32'd10);
      t0 = t1;
    end
    apb_write(A_CTRL, 32'd0);
    repeat (8) @(posedge PCLK);
    apb_read(A_STATUS, 32'h004, 1'b0, "status_4");
    for (int k = 0; k < 4; k++) apb_read(A_DATA, 32'hA001 + 32'(k), 1'b0, "data_order");
    apb_read(A_STATUS, 32'h100, 1'b0, "status_drained");
    apb_read(A_DATA, 32'd0, 1'b1, "data_after_drain");

    apb_write(A_CTRL, 32'd2);
    apb_write(A_WMARK, 32'd4);
    next_val = 16'hA001;
    apb_write(A_CTRL, 32'd1);
    for (int k = 1; k <= 17; k++) begin
      wait_done(t1);
      if (k == 4) begin
        check("irq_at_push4", 32'(irq), 32'd0);
        @(negedge PCLK);
        check("irq_push4_d1", 32'(irq), 32'd0);
        @(negedge PCLK);
        check("irq_push4_d2", 32'(irq), 32'd1);
      end
    end
    apb_write(A_CTRL, 32'd0);
    repeat (5) @(posedge PCLK);
    #1 check("irq_full_ovf", 32'(irq), 32'd1);
    apb_read(A_STATUS, 32'h610, 1'b0, "status_ovf");
    apb_write(A_STATUS, 32'h400);
    apb_read(A_STATUS, 32'h210, 1'b0, "status_ovf_cleared");
    for (int k = 0; k < 13; k++) apb_read(A_DATA, 32'hA001 + 32'(k), 1'b0, "data_full_keep");
    @(posedge PCLK);
    #1 check("irq_drained_to_3", 32'(irq), 32'd0);
    for (int k = 13; k < 16; k++) apb_read(A_DATA, 32'hA001 + 32'(k), 1'b0, "data_full_keep");
    apb_read(A_STATUS, 32'h100, 1'b0, "status_empty2");

    apb_write(A_CTRL, 32'd2);
    lat = 12;
    next_val = 16'hC001;
    apb_write(A_CTRL, 32'd1);
    wait_start(t0);
    for (int k = 0; k < 3; k++) begin
      wait_start(t1);
      check("start_period_late", 32'(t1 - t0), 32'd20);
      t0 = t1;
    end
    apb_write(A_CTRL, 32'd0);
    repeat (16) @(posedge PCLK);
    apb_read(A_STATUS, 32'h804, 1'b0, "status_late");
    for (int k = 0; k < 4; k++) apb_read(A_DATA, 32'hC001 + 32'(k), 1'b0, "data_late");
    apb_write(A_STATUS, 32'h800);
    apb_read(A_STATUS, 32'h100, 1'b0, "status_late_cleared");

    apb_write(A_CTRL, 32'd2);
    apb_write(A_WMARK, 32'd0);
    lat = 3;
    next_val = 16'hB001;
    apb_write(A_CTRL, 32'd1);
    for (int k = 0; k < 16; k++) wait_start(t1);
    wait_start(t1);
    @(posedge PCLK);
    apb_read(A_DATA, 32'hB001, 1'b0, "pop_push_full");
    apb_write(A_CTRL, 32'd0);
    repeat (4) @(posedge PCLK);
    apb_read(A_STATUS, 32'h210, 1'b0, "status_full_no_ovf");
    #1 check("irq_full_no_ovf", 32'(irq), 32'd0);
    for (int k = 0; k < 16; k++) apb_read(A_DATA, 32'hB002 + 32'(k), 1'b0, "data_after_swap");
    apb_read(A_STATUS, 32'h100, 1'b0, "status_empty3");

    apb_write(A_CTRL, 32'd2);
    apb_write(A_WMARK, 32'd1);
    lat = 6;
    next_val = 16'hD001;
    apb_write(A_CTRL, 32'd1);
    wait_start(t0);
    apb_write(A_CTRL, 32'd0);
    n0 = start_cnt;
    repeat (30) @(posedge PCLK);
    #1 check("no_start_after_en_off", 32'(start_cnt), 32'(n0));
    check("irq_wmark1", 32'(irq), 32'd1);
    apb_read(A_STATUS, 32'h001, 1'b0, "status_wait_capture");
    spi_mute = 1'b1;
    apb_write(A_CTRL, 32'd1);
    wait_start(t0);
    @(posedge PCLK);
    @(posedge PCLK);
    #1 PRESETn = 1'b0;
    #1 check("midwait_rst_spi_start", 32'(spi_start), 32'd0);
    check("midwait_rst_irq", 32'(irq), 32'd0);
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    spi_mute = 1'b0;
    apb_read(A_STATUS, 32'h100, 1'b0, "rst2_status");
    apb_read(A_CTRL, 32'd0, 1'b0, "rst2_ctrl");
    apb_read(A_DIV, 32'd1000, 1'b0, "rst2_div");
    apb_read(A_WMARK, 32'd8, 1'b0, "rst2_wmark");

    repeat (5) @(posedge PCLK);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending_reads: got %0d outstanding expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
